// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: turns vblank entries into game ticks and sequences
// up to eight update engines per tick, flagging any engine that overruns.
module frame_update_scheduler #(
  parameter int NUM_TASKS = 4,
  parameter int TICK_DIV  = 1,
  parameter int TIMEOUT   = 40000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hCount,
  input  logic [9:0]           vCount,
  input  logic [NUM_TASKS-1:0] task_en,
  input  logic [NUM_TASKS-1:0] task_done,
  input  logic                 overrun_clr,
  output logic [NUM_TASKS-1:0] task_start,
  output logic                 frame_tick,
  output logic                 update_done,
  output logic                 busy,
  output logic                 overrun,
  output logic [2:0]           overrun_task,
  output logic [15:0]          tick_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [7:0]    DIV_MAX  = 8'(TICK_DIV - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NUM_TASKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    NEXT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          vblank_q, vblank_d;
  logic          vblank_prev_q, vblank_prev_d;
  logic          sampled_q, sampled_d;
  logic          seen_low_q, seen_low_d;
  logic [7:0]    div_q, div_d;
  logic          frame_tick_q, frame_tick_d;
  logic [15:0]   tick_count_q, tick_count_d;
  logic          update_done_q, update_done_d;
  logic          overrun_q, overrun_d;
  logic [2:0]    overrun_task_q, overrun_task_d;
  logic          vblank_rise;
  logic          set_ovr;
  logic [7:0]    en_ext;
  logic [7:0]    done_ext;
  logic          unused_hcount;

  assign unused_hcount = ^hCount;
  assign en_ext        = 8'(task_en);
  assign done_ext      = 8'(task_done);

  // vblank detection and tick divider; a rise only counts once vblank was seen low
  always_comb begin
    vblank_d      = (vCount < 10'd35) || (vCount > 10'd515);
    vblank_prev_d = vblank_q;
    sampled_d     = 1'b1;
    seen_low_d    = seen_low_q | (sampled_q & ~vblank_q);
    vblank_rise   = vblank_q & ~vblank_prev_q & seen_low_q;
    div_d         = div_q;
    frame_tick_d  = 1'b0;
    tick_count_d  = tick_count_q;
    if (vblank_rise) begin
      if (div_q == DIV_MAX) begin
        div_d        = 8'd0;
        frame_tick_d = 1'b1;
        tick_count_d = tick_count_q + 16'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end else begin
      div_d = div_q;
    end
  end

  // sequencing FSM plus overrun bookkeeping
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tmr_d          = tmr_q;
    update_done_d  = 1'b0;
    set_ovr        = 1'b0;
    overrun_task_d = overrun_task_q;
    case (state_q)
      IDLE: begin
        if (frame_tick_q) begin
          idx_d   = 3'd0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tmr_d = {TW{1'b0}};
        if (en_ext[idx_q]) begin
          state_d = WAIT;
        end else begin
          state_d = NEXT;
        end
      end
      WAIT: begin
        tmr_d = tmr_q + TW'(1);
        // completion beats a coincident abort
        if (done_ext[idx_q]) begin
          state_d = NEXT;
        end else if (!vblank_q || (tmr_q == TMAX)) begin
          set_ovr        = 1'b1;
          overrun_task_d = idx_q;
          state_d        = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          update_done_d = 1'b1;
          state_d       = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (frame_tick_q && (state_q != IDLE)) begin
      set_ovr        = 1'b1;
      overrun_task_d = idx_q;
    end else begin
      set_ovr = set_ovr;
    end
    if (set_ovr) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= 3'd0;
      tmr_q          <= {TW{1'b0}};
      vblank_q       <= 1'b0;
      vblank_prev_q  <= 1'b0;
      sampled_q      <= 1'b0;
      seen_low_q     <= 1'b0;
      div_q          <= 8'd0;
      frame_tick_q   <= 1'b0;
      tick_count_q   <= 16'd0;
      update_done_q  <= 1'b0;
      overrun_q      <= 1'b0;
      overrun_task_q <= 3'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tmr_q          <= tmr_d;
      vblank_q       <= vblank_d;
      vblank_prev_q  <= vblank_prev_d;
      sampled_q      <= sampled_d;
      seen_low_q     <= seen_low_d;
      div_q          <= div_d;
      frame_tick_q   <= frame_tick_d;
      tick_count_q   <= tick_count_d;
      update_done_q  <= update_done_d;
      overrun_q      <= overrun_d;
      overrun_task_q <= overrun_task_d;
    end
  end

  // start strobe is decoded from the registered state and slot index
  always_comb begin
    task_start = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if ((state_q == START) && en_ext[idx_q] && (idx_q == 3'(i))) begin
        task_start[i] = 1'b1;
      end else begin
        task_start[i] = 1'b0;
      end
    end
  end

  assign frame_tick   = frame_tick_q;
  assign update_done  = update_done_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign overrun_task = overrun_task_q;
  assign tick_count   = tick_count_q;

endmodule
